// File: rtl/ldpc_encoder_pkg.sv
// ldpc_encoder_pkg: shared types and defaults for the LDPC encoder slice.
// Holds the combiner FSM state encoding and default sizing constants.
package ldpc_encoder_pkg;

  localparam int WIDTH_DEF             = 96;
  localparam int FRAME_LENGTH_DEF      = 11;
  localparam int FRAME_COUNT_WIDTH_DEF = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_INIT        = 2'd0;
  localparam state_t ST_FRAME_START = 2'd1;
  localparam state_t ST_FRAME_BODY  = 2'd2;

endpackage

// File: rtl/ldpc_xor_frame_combiner_if.sv
// ldpc_xor_frame_combiner_if: stream A/B inputs, combined output, frame count.
// slave = combiner side, master = upstream/downstream side.
import ldpc_encoder_pkg::*;

interface ldpc_xor_frame_combiner_if #(
  parameter int WIDTH             = WIDTH_DEF,
  parameter int FRAME_COUNT_WIDTH = FRAME_COUNT_WIDTH_DEF
);

  logic [WIDTH-1:0]             i_a_data;
  logic                         i_a_valid;
  logic                         o_a_ready;
  logic [WIDTH-1:0]             i_b_data;
  logic                         i_b_valid;
  logic                         o_b_ready;
  logic [WIDTH-1:0]             o_output_data;
  logic                         o_output_valid;
  logic                         o_output_last;
  logic                         i_output_ready;
  logic [FRAME_COUNT_WIDTH-1:0] o_frame_count;

  modport slave (
    input  i_a_data, i_a_valid,
    output o_a_ready,
    input  i_b_data, i_b_valid,
    output o_b_ready,
    output o_output_data, o_output_valid, o_output_last,
    input  i_output_ready,
    output o_frame_count
  );

  modport master (
    output i_a_data, i_a_valid,
    input  o_a_ready,
    output i_b_data, i_b_valid,
    input  o_b_ready,
    input  o_output_data, o_output_valid, o_output_last,
    output i_output_ready,
    input  o_frame_count
  );

endinterface

// File: rtl/ldpc_xor_frame_combiner_fifo.sv
// ldpc_skid_fifo2: 2-entry registered FIFO, payload width W.
// Ports: i_push/i_push_data in, i_pop in, o_data/o_valid/o_count out.
module ldpc_skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic [1:0]   o_count
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   count_q;
  logic         pop;

  assign pop     = i_pop && (count_q != 2'd0);
  assign o_valid = (count_q != 2'd0);
  assign o_data  = o_valid ? head_q : '0;
  assign o_count = count_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({i_push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= i_push_data;
          else                 tail_q <= i_push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Count stays put; the new word goes behind whatever remains.
          if (count_q == 2'd1) begin
            head_q <= i_push_data;
          end else begin
            head_q <= tail_q;
            tail_q <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ldpc_xor_frame_combiner.sv
// ldpc_xor_frame_combiner: word-wise XOR join of streams A and B into frames.
// Ports: i_clock, i_reset (async high), bus (slave modport); optional
// i_bypass_b when LDPC_XOR_FRAME_COMBINER_BYPASS_EN is defined.
module ldpc_xor_frame_combiner
  import ldpc_encoder_pkg::*;
#(
  parameter int WIDTH             = WIDTH_DEF,
  parameter int FRAME_LENGTH      = FRAME_LENGTH_DEF,
  parameter int FRAME_COUNT_WIDTH = FRAME_COUNT_WIDTH_DEF
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
`ifdef LDPC_XOR_FRAME_COMBINER_BYPASS_EN
  input  logic                       i_bypass_b,
`endif
  ldpc_xor_frame_combiner_if.slave   bus
);

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LENGTH - 1);

  state_t                       state_q;
  state_t                       state_d;
  logic [7:0]                   word_q;
  logic [FRAME_COUNT_WIDTH-1:0] frames_q;
  logic [1:0]                   fifo_count;
  logic                         ready;
  logic                         fire;
  logic                         last;
  logic [WIDTH-1:0]             word;

  // Readies depend only on registered state and buffer occupancy.
  assign ready = (state_q != ST_INIT) && (fifo_count != 2'd2);
  assign last  = (word_q == LAST_IDX);

`ifdef LDPC_XOR_FRAME_COMBINER_BYPASS_EN
  logic byp_q;
  logic bypass;

  // The first word of a frame already follows the request being latched.
  assign bypass = (state_q == ST_FRAME_START) ? i_bypass_b : byp_q;
  assign fire   = bus.i_a_valid && ready && (bypass || bus.i_b_valid);
  assign word   = bypass ? bus.i_a_data : (bus.i_a_data ^ bus.i_b_data);
  assign bus.o_b_ready = ready && !bypass;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) byp_q <= 1'b0;
    else if (fire && (state_q == ST_FRAME_START)) byp_q <= i_bypass_b;
  end
`else
  assign fire = bus.i_a_valid && bus.i_b_valid && ready;
  assign word = bus.i_a_data ^ bus.i_b_data;
  assign bus.o_b_ready = ready;
`endif

  assign bus.o_a_ready     = ready;
  assign bus.o_frame_count = frames_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:        state_d = ST_FRAME_START;
      ST_FRAME_START: if (fire && (FRAME_LENGTH != 1)) state_d = ST_FRAME_BODY;
      ST_FRAME_BODY:  if (fire && last) state_d = ST_FRAME_START;
      default:        state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_INIT;
      word_q   <= 8'd0;
      frames_q <= '0;
    end else begin
      state_q <= state_d;
      if (fire) begin
        word_q <= last ? 8'd0 : word_q + 8'd1;
        if (last) frames_q <= frames_q + 1'b1;
      end
    end
  end

  ldpc_skid_fifo2 #(
    .W (WIDTH + 1)
  ) u_fifo (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_push      (fire),
    .i_push_data ({word, last}),
    .i_pop       (bus.i_output_ready),
    .o_data      ({bus.o_output_data, bus.o_output_last}),
    .o_valid     (bus.o_output_valid),
    .o_count     (fifo_count)
  );

endmodule

// File: tb/tb_ldpc_xor_frame_combiner.sv
// tb_ldpc_xor_frame_combiner: directed bench for the XOR frame combiner.
// A second instance with a 2-bit frame counter shares the same stimulus.
module tb_ldpc_xor_frame_combiner;
  import ldpc_encoder_pkg::*;

  localparam int W = 96;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ldpc_xor_frame_combiner_if #(.WIDTH(W), .FRAME_COUNT_WIDTH(16)) bus1 ();
  ldpc_xor_frame_combiner_if #(.WIDTH(W), .FRAME_COUNT_WIDTH(2))  bus2 ();

  assign bus2.i_a_data       = bus1.i_a_data;
  assign bus2.i_a_valid      = bus1.i_a_valid;
  assign bus2.i_b_data       = bus1.i_b_data;
  assign bus2.i_b_valid      = bus1.i_b_valid;
  assign bus2.i_output_ready = bus1.i_output_ready;

  ldpc_xor_frame_combiner #(
    .WIDTH(W), .FRAME_LENGTH(11), .FRAME_COUNT_WIDTH(16)
  ) dut1 (
    .i_clock (clk),
    .i_reset (rst),
`ifdef LDPC_XOR_FRAME_COMBINER_BYPASS_EN
    .i_bypass_b (1'b0),
`endif
    .bus     (bus1)
  );

  ldpc_xor_frame_combiner #(
    .WIDTH(W), .FRAME_LENGTH(11), .FRAME_COUNT_WIDTH(2)
  ) dut2 (
    .i_clock (clk),
    .i_reset (rst),
`ifdef LDPC_XOR_FRAME_COMBINER_BYPASS_EN
    .i_bypass_b (1'b0),
`endif
    .bus     (bus2)
  );

  task automatic chk(input string tag, input logic [W-1:0] o,
                     input logic [W-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic chk1(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, o, e);
    end
  endtask

  task automatic chkn(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic va, input logic vb,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    bus1.i_a_valid = va;
    bus1.i_b_valid = vb;
    bus1.i_a_data  = a;
    bus1.i_b_data  = b;
  endtask

  // One full frame at one word per cycle; output trails the fire by a cycle.
  task automatic run_frame(input logic [W-1:0] seed,
                           input int fc1, input int fc2);
    for (int k = 0; k < 11; k++) begin
      drive(1'b1, 1'b1, seed << k, 96'hFFFF);
      step();
      chk1("frm_valid", bus1.o_output_valid, 1'b1);
      chk("frm_data", bus1.o_output_data, (seed << k) ^ 96'hFFFF);
      chk1("frm_last", bus1.o_output_last, k == 10);
    end
    chkn("frm_count", int'(bus1.o_frame_count), fc1);
    chkn("frm_count_w2", int'(bus2.o_frame_count), fc2);
  endtask

  initial begin
    drive(1'b0, 1'b0, '0, '0);
    bus1.i_output_ready = 1'b1;

    // Reset held, then released.
    step();
    step();
    chk1("rst_a_ready", bus1.o_a_ready, 1'b0);
    chk1("rst_b_ready", bus1.o_b_ready, 1'b0);
    chk1("rst_valid", bus1.o_output_valid, 1'b0);
    chk("rst_data", bus1.o_output_data, '0);
    chkn("rst_count", int'(bus1.o_frame_count), 0);
    rst = 1'b0;
    chk1("init_ready", bus1.o_a_ready, 1'b0);
    step();
    chk1("start_a_ready", bus1.o_a_ready, 1'b1);
    chk1("start_b_ready", bus1.o_b_ready, 1'b1);
    chk1("start_valid", bus1.o_output_valid, 1'b0);
    chkn("start_count", int'(bus1.o_frame_count), 0);

    // Streaming frame: (1<<k) ^ FFFF.
    run_frame(96'h1, 1, 1);
    drive(1'b0, 1'b0, '0, '0);
    step();
    chk1("drain_valid", bus1.o_output_valid, 1'b0);

    // Join stall: A alone never fires.
    drive(1'b1, 1'b0, 96'hABC, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("stall_a_ready", bus1.o_a_ready, 1'b1);
      chk1("stall_b_ready", bus1.o_b_ready, 1'b1);
      chk1("stall_valid", bus1.o_output_valid, 1'b0);
    end
    drive(1'b1, 1'b1, 96'hABC, 96'h123);
    step();
    chk1("join_valid", bus1.o_output_valid, 1'b1);
    chk("join_data", bus1.o_output_data, 96'hB9F);
    chk1("join_last", bus1.o_output_last, 1'b0);
    drive(1'b0, 1'b0, '0, '0);
    step();
    chk1("join_drain", bus1.o_output_valid, 1'b0);

    // Backpressure: two fires fill the buffer, then readies drop.
    bus1.i_output_ready = 1'b0;
    drive(1'b1, 1'b1, 96'h100, '0);
    step();
    chk1("bp1_ready", bus1.o_a_ready, 1'b1);
    chk("bp1_data", bus1.o_output_data, 96'h100);
    drive(1'b1, 1'b1, 96'h101, '0);
    step();
    chk1("bp2_ready", bus1.o_a_ready, 1'b0);
    chk("bp2_data", bus1.o_output_data, 96'h100);
    drive(1'b1, 1'b1, 96'h102, '0);
    step();
    chk1("bp3_ready", bus1.o_b_ready, 1'b0);
    chk1("bp3_valid", bus1.o_output_valid, 1'b1);
    chk("bp3_data", bus1.o_output_data, 96'h100);
    chk1("bp3_last", bus1.o_output_last, 1'b0);
    drive(1'b0, 1'b0, '0, '0);
    bus1.i_output_ready = 1'b1;
    step();
    chk1("bp4_valid", bus1.o_output_valid, 1'b1);
    chk("bp4_data", bus1.o_output_data, 96'h101);
    chk1("bp4_ready", bus1.o_a_ready, 1'b1);
    step();
    chk1("bp5_valid", bus1.o_output_valid, 1'b0);

    // Three more words: six words into the frame.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 96'h200 + 96'(i), '0);
      step();
      chk("mid_data", bus1.o_output_data, 96'h200 + 96'(i));
    end
    drive(1'b0, 1'b0, '0, '0);
    chk1("pre_rst_valid", bus1.o_output_valid, 1'b1);

    // Mid-frame asynchronous reset.
    rst = 1'b1;
    #1;
    chk1("arst_valid", bus1.o_output_valid, 1'b0);
    chk("arst_data", bus1.o_output_data, '0);
    chk1("arst_ready", bus1.o_a_ready, 1'b0);
    chkn("arst_count", int'(bus1.o_frame_count), 0);
    step();
    rst = 1'b0;
    step();

    // Fresh frames; 2-bit counter wraps 1,2,3,0,1.
    run_frame(96'h3, 1, 1);
    run_frame(96'h5, 2, 2);
    run_frame(96'h7, 3, 3);
    run_frame(96'h9, 4, 0);
    run_frame(96'hB, 5, 1);
    drive(1'b0, 1'b0, '0, '0);
    step();
    chk1("end_valid", bus1.o_output_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldpc_xor_frame_combiner.md
Name: ldpc_xor_frame_combiner

Overview:
- Sits directly downstream of the sparse multiply-by-B stage in the LDPC encoder.
- Joins two framed word streams word by word: stream A comes from the multiply-by-B stage, stream B comes from the parallel sparse-multiply path. Each frame is FRAME_LENGTH words.
- Outputs the bitwise XOR of the two streams as framed words, with a last flag and a running frame count, toward the parity accumulator.
- A 2-entry output buffer decouples input ready from output ready.

Parameters:
- WIDTH, 96, data word width in bits.
- FRAME_LENGTH, 11, words per frame; legal range 1..255.
- FRAME_COUNT_WIDTH, 16, width of the frame counter.

Ports:
- i_clock  input  1  single clock; all state on the rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_a_data  input  WIDTH  stream A word.
- i_a_valid  input  1  stream A valid.
- o_a_ready  output  1  stream A ready.
- i_b_data  input  WIDTH  stream B word.
- i_b_valid  input  1  stream B valid.
- o_b_ready  output  1  stream B ready.
- o_output_data  output  WIDTH  combined word.
- o_output_valid  output  1  output valid.
- o_output_last  output  1  high on the final word of a frame.
- i_output_ready  input  1  downstream ready.
- o_frame_count  output  FRAME_COUNT_WIDTH  number of frames fully accepted at the input; wraps at 2^FRAME_COUNT_WIDTH.

Behaviour:
- Reset: i_reset is asynchronous and active-high.
  - All outputs go to 0 while reset is asserted. This covers the readies, valid, last, data and frame count.
  - The buffer is emptied, the word counter goes to 0, and the state machine goes to ST_INIT.
  - Asserting reset mid-frame discards any partial frame and all buffered words.
- State machine, states ST_INIT, ST_FRAME_START, ST_FRAME_BODY:
  - ST_INIT goes to ST_FRAME_START on the next clock. Readies are low in ST_INIT.
  - ST_FRAME_START goes to ST_FRAME_BODY on a fire. If FRAME_LENGTH==1, it stays in ST_FRAME_START instead.
  - ST_FRAME_BODY goes to ST_FRAME_START on a fire while word_count==FRAME_LENGTH-1.
- Ready:
  - o_a_ready = o_b_ready = (state != ST_INIT) && (buffer_count < 2).
  - Readies come only from registered state. They have no combinational path from i_output_ready or from the valids.
- Fire: occurs when i_a_valid && i_b_valid && o_a_ready.
  - Both streams are consumed together, in the same cycle.
  - A valid word on one stream alone is never consumed; it waits for its partner.
- Word counter: counts 0..FRAME_LENGTH-1, advances on each fire, and wraps to 0 after the last word.
- Frame counter: increments on the fire of the last word and wraps naturally.
- Data path:
  - Buffer entry = {i_a_data ^ i_b_data, last}, where last = (word_count==FRAME_LENGTH-1).
  - Latency: a word fired in cycle N is visible on the output in cycle N+1 when the buffer was empty.
- Buffer: 2-entry FIFO.
  - Pushes on fire, pops when o_output_valid && i_output_ready.
  - A simultaneous push and pop leaves the count unchanged and preserves order.
  - A push is never attempted when the count is 2, because the readies are low.
  - When the count is 0, o_output_valid = 0 and o_output_data = 0.
  - While i_output_ready is low, the output word and last flag stay stable.
- Throughput: one word per cycle sustained when both valids and i_output_ready are held high.

Optional Feature:
- Macro: LDPC_XOR_FRAME_COMBINER_BYPASS_EN.
- When defined:
  - Adds input port i_bypass_b (1 bit).
  - i_bypass_b is sampled on the first fire of each frame in ST_FRAME_START and latched for the whole frame.
  - While the latch is set:
    - Fire = i_a_valid && o_a_ready.
    - o_b_ready = 0.
    - Output word = i_a_data.
    - Stream B is untouched for that frame.
  - The latch is cleared by reset.
- When undefined: the port is absent and both streams are always joined.

Decomposition:
- Package ldpc_encoder_pkg holds:
  - the state typedef (ST_INIT, ST_FRAME_START, ST_FRAME_BODY);
  - the default WIDTH (96), FRAME_LENGTH (11) and FRAME_COUNT_WIDTH (16) constants.
- One sub-module: ldpc_skid_fifo2.
  - A 2-entry registered FIFO parameterised on payload width.
  - Instantiated here with payload width WIDTH+1 (data plus last).

Test Plan:
- Reset release: after reset, readies are 0 for one cycle, then 1. o_output_valid = 0 and o_frame_count = 0.
- Streaming: A word k = 96'h1 << k and B word k = 96'hFFFF, k = 0..10, both valids high, i_output_ready=1. Expect 11 outputs (1<<k)^96'hFFFF at one per cycle. o_output_last is high only on k=10. o_frame_count becomes 1 after the 11th fire.
- Join stall: A valid for 3 cycles before B is valid. Expect no fire and the readies to stay high. The fire occurs in the first cycle B is valid, and the output appears the next cycle.
- Backpressure: i_output_ready=0 with continuous input. Expect exactly 2 fires, then the readies drop. The output holds word 0. When ready returns, the words emerge in order with none lost or duplicated.
- Frame count wrap: with FRAME_COUNT_WIDTH=2, run 5 frames. Expect o_frame_count to sequence 1,2,3,0,1.
- Mid-frame reset: assert reset after 6 words. Expect the outputs to clear asynchronously. The next frame's o_output_last falls on its 11th word, not its 5th.
